// File: rtl/uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// uart_rx_8n1
//   8N1 UART receiver. Oversamples the asynchronous serial line with
//   CLKS_PER_BIT clocks per bit and samples each bit at its midpoint. Each
//   received byte goes into a one-byte holding register and is offered to the
//   consumer over a valid/ready handshake.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (>= 4, even)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous reset, active low
//   ser_in    in   serial line, idle high, asynchronous to clk
//   rx_data   out  received byte, valid while rx_valid = 1
//   rx_valid  out  holding register full
//   rx_ready  in   consumer takes the byte when rx_valid && rx_ready
//   frame_err out  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun   out  one-cycle pulse: byte finished while holding reg full, new byte lost
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  logic             w_s_in;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic             w_shift_en;
  logic             w_stop_ok;
  logic             w_stop_bad;
  logic             w_take;

  // Synchroniser: resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ser_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_in = r_sync2;

  // Frame FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_WAIT_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  // Frame FSM: next state. The start bit is checked at its midpoint; from then
  // on every sample is a full bit period later, landing mid-bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_en    = 1'b0;
    w_stop_ok     = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      S_WAIT_IDLE: begin
        if (w_s_in) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!w_s_in) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = '0;
          if (!w_s_in) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt     = '0;
          w_shift_en    = 1'b1;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt = '0;
          if (w_s_in) begin
            // Back to IDLE right at mid stop bit so a following start edge is caught.
            w_stop_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_WAIT_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Shift register: LSB arrives first, so bits enter at the top and move down.
  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift <= {w_s_in, r_shift[7:1]};
  end

  assign w_take = rx_valid & rx_ready;

  // Holding register and status pulses. A byte finishing in the same cycle the
  // old one is taken simply replaces it, keeping rx_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;
      overrun   <= w_stop_ok & rx_valid & ~rx_ready;
      if (w_stop_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (w_take) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
`timescale 1ns/1ps

module tb_uart_rx_8n1;

  localparam int CPB = 16;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       ser_in   = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int total  = 0;
  int bad    = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int acc_cnt = 0;

  // Reference model: the bytes the consumer must see, in order.
  logic [7:0] exp_q[$];

  logic prev_valid = 1'b0;
  time  t_fall = 0;
  time  t_rise = 0;

  always #5 clk = ~clk;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Observer: counts status pulses and scores every handshake against the model.
  always @(negedge clk) begin
    if (frame_err || overrun)
      check_val("fe_ov_exclusive", 32'(frame_err & overrun), 32'd0);
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (rx_valid && !prev_valid) t_rise = $time;
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0)
        check_val("unexpected_byte", 32'(rx_data), 32'h100);
      else
        check_val("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  // Drive the first ncyc clock cycles of an 8N1 frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ncyc);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int c = 0; c < ncyc && c < 10 * CPB; c++) begin
      @(posedge clk);
      #1;
      ser_in = fr[c / CPB];
      if (c == 0) t_fall = $time;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      ser_in = 1'b1;
    end
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int         fe0, ov0, a0, lat, ngood, nbad, gap;
    logic [7:0] b;
    logic       bs;

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(rx_valid), 32'd0);
    check_val("rst_data",  32'(rx_data),  32'd0);
    check_val("rst_fe",    32'(frame_err), 32'd0);
    check_val("rst_ov",    32'(overrun),  32'd0);
    reset = 1'b1;
    idle(4);

    // 1: single byte held until consumed
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 10 * CPB);
    check_val("t1_valid", 32'(rx_valid), 32'd1);
    check_val("t1_data",  32'(rx_data),  32'hA5);
    lat = int'((t_rise - t_fall) / 10);
    check_val("t1_latency_154_156", 32'(lat >= 154 && lat <= 156), 32'd1);
    idle(50);
    check_val("t1_hold_valid", 32'(rx_valid), 32'd1);
    check_val("t1_hold_data",  32'(rx_data),  32'hA5);
    a0 = acc_cnt;
    pulse_ready();
    check_val("t1_drop_valid", 32'(rx_valid), 32'd0);
    check_val("t1_accepted", acc_cnt - a0, 32'd1);

    // 2: back-to-back frames with consumer always ready
    fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 10 * CPB);
    send_frame(8'hFF, 1'b1, 10 * CPB);
    idle(4);
    check_val("t2_accepted", acc_cnt - a0, 32'd2);
    check_val("t2_fe", fe_cnt - fe0, 32'd0);
    check_val("t2_ov", ov_cnt - ov0, 32'd0);
    check_val("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: framing error, then recovery
    rx_ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 10 * CPB);
    idle(CPB);
    check_val("t3_fe_pulse", fe_cnt - fe0, 32'd1);
    check_val("t3_ov", ov_cnt - ov0, 32'd0);
    check_val("t3_valid_low", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 10 * CPB);
    check_val("t3_next_valid", 32'(rx_valid), 32'd1);
    check_val("t3_next_data",  32'(rx_data),  32'h5A);
    pulse_ready();
    check_val("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: short low glitch is rejected
    fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
    @(posedge clk);
    #1 ser_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 ser_in = 1'b1;
    idle(3 * CPB);
    check_val("t4_valid", 32'(rx_valid), 32'd0);
    check_val("t4_fe", fe_cnt - fe0, 32'd0);
    check_val("t4_ov", ov_cnt - ov0, 32'd0);
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 10 * CPB);
    idle(4);
    check_val("t4_after_glitch_acc", acc_cnt - a0, 32'd1);
    rx_ready = 1'b0;

    // 5: overrun keeps the first byte
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 10 * CPB);
    idle(CPB);
    send_frame(8'h22, 1'b1, 10 * CPB);
    idle(4);
    check_val("t5_ov_pulse", ov_cnt - ov0, 32'd1);
    check_val("t5_fe", fe_cnt - fe0, 32'd0);
    check_val("t5_valid", 32'(rx_valid), 32'd1);
    check_val("t5_data",  32'(rx_data),  32'h11);
    pulse_ready();
    check_val("t5_valid_after", 32'(rx_valid), 32'd0);
    check_val("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: asynchronous reset mid-frame
    send_frame(8'h77, 1'b1, 10 * CPB);
    check_val("t6_pre_valid", 32'(rx_valid), 32'd1);
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h96, 1'b1, 5 * CPB + CPB / 2);
    #2 reset = 1'b0;
    #1;
    check_val("t6_rst_valid", 32'(rx_valid), 32'd0);
    check_val("t6_rst_data",  32'(rx_data),  32'd0);
    check_val("t6_rst_fe",    32'(frame_err), 32'd0);
    check_val("t6_rst_ov",    32'(overrun),  32'd0);
    ser_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2 * CPB);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 10 * CPB);
    check_val("t6_valid", 32'(rx_valid), 32'd1);
    check_val("t6_data",  32'(rx_data),  32'h81);
    pulse_ready();
    check_val("t6_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    // Randomized traffic: random bytes, random gaps, occasional bad stop bit.
    rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
    ngood = 0; nbad = 0;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      bs = ($urandom_range(0, 4) != 0);
      if (bs) begin
        exp_q.push_back(b);
        ngood++;
      end else begin
        nbad++;
      end
      send_frame(b, bs, 10 * CPB);
      gap = bs ? int'($urandom_range(0, 2 * CPB)) : CPB + int'($urandom_range(0, CPB));
      idle(gap);
    end
    idle(4);
    check_val("rnd_accepted", acc_cnt - a0, ngood);
    check_val("rnd_fe", fe_cnt - fe0, nbad);
    check_val("rnd_ov", ov_cnt - ov0, 32'd0);
    check_val("rnd_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
